if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 8-bit pipelined processor, sitting directly downstream of the program counter. Each cycle it reads the byte at PC and the byte at PC+1 from the dual-read instruction memory, classifies the instruction as one- or two-byte, and tells the PC whether to advance by 1 or 2. Its output is the IF/ID pipeline register for decode. It also sequences interrupt entry: it drains fetch, selects the interrupt vector, and hands decode an interrupt marker carrying the return address.

## Interface
- IMM_OPCODE, 4'hC: value of opcode[7:4] that marks a two-byte instruction; the immediate is the following byte.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- pc  in  8  current PC value.
- stall  in  1  hazard stall from decode/hazard unit; holds IF/ID and the PC.
- flush  in  1  taken branch/jump in execute; IF/ID becomes a bubble.
- irq  in  1  external interrupt request, level; sampled each cycle.
- imem_addr0  out  8  = pc, combinational.
- imem_addr1  out  8  = pc+1 mod 256, combinational.
- imem_data0  in  8  byte at imem_addr0, same-cycle (combinational) read.
- imem_data1  in  8  byte at imem_addr1, same-cycle read.
- pc_en  out  1  PC update enable.
- pc_imm  out  1  1 when imem_data0[7:4]==IMM_OPCODE (PC+2), else 0 (PC+1).
- pc_int  out  1  one-cycle pulse forcing the PC to load the vector.
- vec_sel  out  1  vector mux select, 0 = M[0] (reset), 1 = M[1] (interrupt).
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  8  opcode byte.
- ifid_imm  out  8  immediate byte; 0 for one-byte instructions.
- ifid_is_imm  out  1  instruction is two-byte.
- ifid_pc_next  out  8  address of the next sequential instruction (pc+1 or pc+2, mod 256).
- ifid_int  out  1  IF/ID holds an interrupt marker.

## Operation
- FSM states: RUN, IRQ_DRAIN, IRQ_VEC.
- Reset (rst==0): state RUN; all IF/ID outputs 0; pc_int 0; vec_sel 0; irq latch 0. The PC loads M[0] itself while rst is low.
- RUN:
  - pc_en=1 and pc_imm is decoded from imem_data0.
  - When !stall and !flush, IF/ID captures: valid=1, instr=data0, is_imm, imm=(is_imm?data1:0), pc_next=pc+1 or pc+2.
  - If irq==1 in a cycle where IF/ID advances, that fetch still completes. The irq latch sets and the state moves to IRQ_DRAIN.
- IRQ_DRAIN:
  - pc_en=0 and pc_imm=0.
  - The stage waits for !stall; the cycle with !stall is the capture cycle.
  - In the capture cycle it captures ret = pc, writes a bubble into IF/ID, and moves to IRQ_VEC.
- IRQ_VEC (one cycle):
  - pc_int=1, vec_sel=1, pc_en=0.
  - IF/ID captures the marker: ifid_int=1, valid=0, pc_next=ret, other fields 0.
  - Clears the irq latch and returns to RUN.
- vec_sel is 1 only in IRQ_VEC and 0 otherwise.
- Priority: rst > flush > stall.
  - flush in RUN: IF/ID becomes a bubble (valid=0, int=0, fields 0) even if stall=1.
  - flush in IRQ_DRAIN: ret is taken from the pc value of the capture cycle, which already reflects the branch target. The branch is not lost.
  - flush is ignored in IRQ_VEC; the marker must be written.
- irq is ignored outside RUN. A level still high on return to RUN is serviced only after one instruction has been fetched in RUN.
- Address arithmetic is 8-bit and wraps: pc=8'hFF reads data1 from 8'h00; pc_next for a two-byte instruction at 8'hFF is 8'h01.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: the instruction at pc is visible on the IF/ID outputs after the next rising edge.
- pc_en, pc_imm, imem_addr0/1 and vec_sel are combinational from pc, imem_data0 and state. pc_int is decoded from state; it is not a separate register.
- stall=1 in RUN holds all IF/ID outputs unchanged, and the PC holds because stall also feeds the PC.
- Interrupt entry with no stall takes 3 edges: E1 latch irq (state→IRQ_DRAIN), E2 bubble (state→IRQ_VEC), E3 marker captured and PC loaded with M[1].
- rst low at any edge returns to RUN with a cleared IF/ID, including mid-interrupt. No marker is emitted.

## Test plan
- Reset: hold rst=0 for 2 cycles with pc=8'h10. Required: all ifid_* = 0, pc_int=0, vec_sel=0, state RUN.
- Sequential fetch: mem[8'h20]=8'h45, mem[8'h21]=8'hC1, mem[8'h22]=8'h7E. Drive pc=8'h20 then pc=8'h21. Required:
  - pc_imm=0, then ifid_instr=8'h45, pc_next=8'h21, valid=1.
  - Next: pc_imm=1, then ifid_is_imm=1, imm=8'h7E, pc_next=8'h23.
- Stall vs flush: apply stall=1 for 3 cycles; IF/ID is unchanged each cycle. Then apply stall=1 and flush=1 together; required valid=0 after the edge.
- Wrap: pc=8'hFF, mem[8'hFF]=8'hC0, mem[8'h00]=8'h5A. Required: imem_addr1=8'h00, ifid_imm=8'h5A, pc_next=8'h01.
- Interrupt: irq=1 for 1 cycle at pc=8'h30 (one-byte instruction), with the PC advancing to 8'h31. Required:
  - Next edge: instruction from 8'h30 captured.
  - Then: bubble.
  - Then: ifid_int=1, pc_next=8'h31.
  - pc_int=1 and vec_sel=1 in exactly that cycle; pc_en=0 during drain and vector cycles.
- Reset mid-interrupt: rst=0 in the IRQ_VEC cycle. Required: ifid_int=0, state RUN, and irq held high is re-serviced only after one RUN fetch.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch, one/two-byte classification, IF/ID register and interrupt entry sequencing
//   clk, rst (sync, active-low)  | pc, stall, flush, irq in
//   imem_addr0/1 out, imem_data0/1 in (combinational dual-read memory)
//   pc_en, pc_imm, pc_int, vec_sel out (PC control)
//   ifid_valid, ifid_instr, ifid_imm, ifid_is_imm, ifid_pc_next, ifid_int out (IF/ID register)
module if_stage #(
  parameter logic [3:0] IMM_OPCODE = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pc,
  input  logic       stall,
  input  logic       flush,
  input  logic       irq,
  output logic [7:0] imem_addr0,
  output logic [7:0] imem_addr1,
  input  logic [7:0] imem_data0,
  input  logic [7:0] imem_data1,
  output logic       pc_en,
  output logic       pc_imm,
  output logic       pc_int,
  output logic       vec_sel,
  output logic       ifid_valid,
  output logic [7:0] ifid_instr,
  output logic [7:0] ifid_imm,
  output logic       ifid_is_imm,
  output logic [7:0] ifid_pc_next,
  output logic       ifid_int
);
  typedef enum logic [1:0] {RUN, IRQ_DRAIN, IRQ_VEC} state_t;
  typedef struct packed {
    logic       valid;
    logic [7:0] instr;
    logic [7:0] imm;
    logic       is_imm;
    logic [7:0] pc_next;
    logic       intr;
  } ifid_t;
  state_t     state_q, state_d;
  logic       irq_q, irq_d;
  logic [7:0] ret_q, ret_d;
  ifid_t      ifid_q, ifid_d;
  logic       is_imm;
  assign is_imm       = imem_data0[7:4] == IMM_OPCODE;
  assign imem_addr0   = pc;
  assign imem_addr1   = pc + 8'd1;
  assign pc_en        = state_q == RUN;
  assign pc_imm       = pc_en && is_imm;
  assign pc_int       = state_q == IRQ_VEC;
  assign vec_sel      = pc_int;
  assign ifid_valid   = ifid_q.valid;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_imm     = ifid_q.imm;
  assign ifid_is_imm  = ifid_q.is_imm;
  assign ifid_pc_next = ifid_q.pc_next;
  assign ifid_int     = ifid_q.intr;
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    ret_d   = ret_q;
    ifid_d  = ifid_q;
    case (state_q)
      RUN: begin
        if (flush) ifid_d = '0;
        else if (!stall) begin
          ifid_d = {1'b1, imem_data0, is_imm ? imem_data1 : 8'h00, is_imm,
                    pc + (is_imm ? 8'd2 : 8'd1), 1'b0};
          if (irq) begin
            irq_d   = 1'b1;
            state_d = IRQ_DRAIN;
          end
        end
      end
      // A flush here delays the return-address capture by a cycle so ret picks up the branch target.
      IRQ_DRAIN: begin
        if (flush) ifid_d = '0;
        else if (!stall) begin
          ifid_d  = '0;
          ret_d   = pc;
          state_d = IRQ_VEC;
        end
      end
      IRQ_VEC: begin
        ifid_d  = {1'b0, 16'h0000, 1'b0, ret_q, 1'b1};
        irq_d   = 1'b0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      irq_q   <= 1'b0;
      ret_q   <= 8'h00;
      ifid_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      ret_q   <= ret_d;
      ifid_q  <= ifid_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checking of if_stage against a behavioural fetch/interrupt model
module tb_if_stage;
  logic       clk = 1'b0;
  logic       rst, stall, flush, irq;
  logic [7:0] pc;
  logic [7:0] mem [256];
  logic [7:0] imem_addr0, imem_addr1, imem_data0, imem_data1;
  logic       pc_en, pc_imm, pc_int, vec_sel;
  logic       ifid_valid, ifid_is_imm, ifid_int;
  logic [7:0] ifid_instr, ifid_imm, ifid_pc_next;
  int         errors = 0;
  int         checks = 0;
  int         ph = 0;
  logic [7:0] ret = 8'h00;
  logic       e_valid = 1'b0, e_is_imm = 1'b0, e_int = 1'b0;
  logic [7:0] e_instr = 8'h00, e_imm = 8'h00, e_pcn = 8'h00;
  logic       seen_pc_int;

  always #5 clk = ~clk;

  assign imem_data0 = mem[imem_addr0];
  assign imem_data1 = mem[imem_addr1];

  if_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall), .flush(flush), .irq(irq),
    .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
    .imem_data0(imem_data0), .imem_data1(imem_data1),
    .pc_en(pc_en), .pc_imm(pc_imm), .pc_int(pc_int), .vec_sel(vec_sel),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_imm(ifid_imm),
    .ifid_is_imm(ifid_is_imm), .ifid_pc_next(ifid_pc_next), .ifid_int(ifid_int)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_e(input logic v, input logic [7:0] ins, input logic [7:0] im,
                       input logic ii, input logic [7:0] pn, input logic it);
    e_valid = v; e_instr = ins; e_imm = im; e_is_imm = ii; e_pcn = pn; e_int = it;
  endtask

  // One clock: drive, check combinational outputs, advance model, check IF/ID, move the PC as the PC unit would.
  task automatic step(input logic r, input logic s, input logic f, input logic i);
    logic [7:0] d0, d1, nxt;
    logic       two;
    rst = r; stall = s; flush = f; irq = i;
    #1;
    d0  = mem[pc];
    d1  = mem[8'(pc + 8'd1)];
    two = d0[7:4] == 4'hC;
    seen_pc_int = pc_int;
    chk("addr0", imem_addr0, pc);
    chk("addr1", imem_addr1, 8'(pc + 8'd1));
    chk("pc_en", pc_en, ph == 0);
    chk("pc_imm", pc_imm, ph == 0 && two);
    chk("pc_int", pc_int, ph == 2);
    chk("vec_sel", vec_sel, ph == 2);
    if (!r) nxt = mem[0];
    else if (ph == 2) nxt = mem[1];
    else if (f) nxt = 8'($urandom);
    else if (s || ph != 0) nxt = pc;
    else nxt = 8'(pc + (two ? 8'd2 : 8'd1));
    if (!r) begin
      ph = 0;
      set_e(0, 0, 0, 0, 0, 0);
    end else if (ph == 2) begin
      set_e(0, 0, 0, 0, ret, 1);
      ph = 0;
    end else if (f) set_e(0, 0, 0, 0, 0, 0);
    else if (!s) begin
      if (ph == 0) begin
        set_e(1, d0, two ? d1 : 8'h00, two, 8'(pc + (two ? 8'd2 : 8'd1)), 0);
        if (i) ph = 1;
      end else begin
        set_e(0, 0, 0, 0, 0, 0);
        ret = pc;
        ph  = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("ifid_valid", ifid_valid, e_valid);
    chk("ifid_instr", ifid_instr, e_instr);
    chk("ifid_imm", ifid_imm, e_imm);
    chk("ifid_is_imm", ifid_is_imm, e_is_imm);
    chk("ifid_pc_next", ifid_pc_next, e_pcn);
    chk("ifid_int", ifid_int, e_int);
    pc = nxt;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; irq = 1'b0; pc = 8'h10;
    repeat (2) @(negedge clk);
    // reset
    pc = 8'h10;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_pc_int", pc_int, 0);
    chk("rst_vec_sel", vec_sel, 0);
    // sequential fetch
    mem[8'h20] = 8'h45; mem[8'h21] = 8'hC1; mem[8'h22] = 8'h7E;
    pc = 8'h20;
    step(1, 0, 0, 0);
    chk("seq1_instr", ifid_instr, 8'h45);
    chk("seq1_pcn", ifid_pc_next, 8'h21);
    chk("seq1_valid", ifid_valid, 1);
    pc = 8'h21;
    step(1, 0, 0, 0);
    chk("seq2_is_imm", ifid_is_imm, 1);
    chk("seq2_imm", ifid_imm, 8'h7E);
    chk("seq2_pcn", ifid_pc_next, 8'h23);
    // stall holds, flush beats stall
    repeat (3) begin
      step(1, 1, 0, 0);
      chk("stall_hold_pcn", ifid_pc_next, 8'h23);
    end
    step(1, 1, 1, 0);
    chk("flush_valid", ifid_valid, 0);
    // wrap
    mem[8'hFF] = 8'hC0; mem[8'h00] = 8'h5A;
    pc = 8'hFF;
    step(1, 0, 0, 0);
    chk("wrap_imm", ifid_imm, 8'h5A);
    chk("wrap_pcn", ifid_pc_next, 8'h01);
    // interrupt entry
    mem[8'h30] = 8'h12;
    pc = 8'h30;
    step(1, 0, 0, 1);
    chk("irq_fetch", ifid_instr, 8'h12);
    chk("irq_pc_adv", pc, 8'h31);
    step(1, 0, 0, 0);
    chk("irq_bubble", ifid_valid, 0);
    step(1, 0, 0, 0);
    chk("irq_vec_pulse", seen_pc_int, 1);
    chk("irq_marker", ifid_int, 1);
    chk("irq_ret", ifid_pc_next, 8'h31);
    // reset during the vector cycle, then a held irq
    pc = 8'h30;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rstirq_int", ifid_int, 0);
    pc = 8'h30;
    step(1, 0, 0, 1);
    chk("rstirq_refetch", ifid_valid, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rstirq_marker", ifid_int, 1);
    // randomized traffic
    for (int k = 0; k < 256; k++) mem[k] = ($urandom_range(3) == 0) ? {4'hC, 4'($urandom)} : 8'($urandom);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(99) >= 3, $urandom_range(99) < 25, $urandom_range(99) < 10, $urandom_range(99) < 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
